// File: rtl/pdm_pkg.sv
// Shared types and defaults for the pdm block family.
// Holds the fader state encoding and the default duty/prescale widths.
package pdm_pkg;

    localparam int PDM_DUTY_BITS_DEFAULT     = 8;
    localparam int PDM_PRESCALE_BITS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } pdm_fader_state_t;

endpackage

// File: rtl/pdm_fader_if.sv
// Firmware-facing control/status bundle of pdm_fader.
// The breathe input exists only when PDM_FADER_BREATHE_EN is defined.
interface pdm_fader_if #(
    parameter int DUTY_BITS     = 8,
    parameter int PRESCALE_BITS = 16
);

    logic                     en;
    logic                     load;
    logic [DUTY_BITS-1:0]     target;
    logic [DUTY_BITS-1:0]     step;
    logic [PRESCALE_BITS-1:0] period;
    logic [DUTY_BITS-1:0]     duty;
    logic                     busy;
    logic                     done;
`ifdef PDM_FADER_BREATHE_EN
    logic                     breathe;

    modport master (
        output en, load, target, step, period, breathe,
        input  duty, busy, done
    );

    modport slave (
        input  en, load, target, step, period, breathe,
        output duty, busy, done
    );
`else
    modport master (
        output en, load, target, step, period,
        input  duty, busy, done
    );

    modport slave (
        input  en, load, target, step, period,
        output duty, busy, done
    );
`endif

endinterface

// File: rtl/pdm_prescaler.sv
// Step-period counter: emits a tick every period+1 enabled cycles.
// clear forces the count back to zero (load accepted, or fader idle).
module pdm_prescaler #(
    parameter int PRESCALE_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_clear,
    input  logic [PRESCALE_BITS-1:0] i_period,
    output logic                     o_tick
);

    logic [PRESCALE_BITS-1:0] r_count;
    logic                     w_hit;

    assign w_hit  = (r_count == i_period);
    assign o_tick = i_en & ~i_clear & w_hit;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_clear || w_hit) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdm_fader.sv
// pdm_fader: ramps the pdm duty input linearly toward a firmware target, one step per tick.
// Define PDM_FADER_BREATHE_EN to add the breathe input (continuous up/down cycling).
module pdm_fader
    import pdm_pkg::*;
#(
    parameter int DUTY_BITS     = PDM_DUTY_BITS_DEFAULT,
    parameter int PRESCALE_BITS = PDM_PRESCALE_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    pdm_fader_if.slave bus
);

    pdm_fader_state_t         r_state;
    logic [DUTY_BITS-1:0]     r_duty;
    logic [DUTY_BITS-1:0]     r_target;
    logic [DUTY_BITS-1:0]     r_step;
    logic [DUTY_BITS-1:0]     r_goal;
    logic [PRESCALE_BITS-1:0] r_period;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_load;
    logic                     w_clear;
    logic                     w_tick;
    logic                     w_breathe;
    logic                     w_arrive;
    logic [DUTY_BITS-1:0]     w_step_eff;
    logic [DUTY_BITS-1:0]     w_next_duty;
    logic [DUTY_BITS:0]       w_gap;

`ifdef PDM_FADER_BREATHE_EN
    assign w_breathe = bus.breathe;
`else
    assign w_breathe = 1'b0;
`endif

    assign w_load     = bus.en & bus.load;
    assign w_clear    = w_load | (r_state == IDLE);
    assign w_step_eff = (r_step == '0) ? DUTY_BITS'(1) : r_step;

    pdm_prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .i_en     (bus.en),
        .i_clear  (w_clear),
        .i_period (r_period),
        .o_tick   (w_tick)
    );

    // Distance to the current endpoint is taken one bit wider, so the
    // "close enough" test can never be fooled by wrap-around.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing branch would infer a latch.
        w_gap       = '0;
        w_next_duty = r_duty;
        case (r_state)
            UP: begin
                w_gap       = {1'b0, r_goal} - {1'b0, r_duty};
                w_next_duty = r_duty + w_step_eff;
            end
            DOWN: begin
                w_gap       = {1'b0, r_duty} - {1'b0, r_goal};
                w_next_duty = r_duty - w_step_eff;
            end
            default: ;
        endcase
    end

    assign w_arrive = (w_gap <= {1'b0, w_step_eff});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_duty   <= '0;
            r_target <= '0;
            r_step   <= '0;
            r_goal   <= '0;
            r_period <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.en) begin
            r_done <= 1'b0;
            if (w_load) begin
                r_target <= bus.target;
                r_step   <= bus.step;
                r_period <= bus.period;
                r_goal   <= bus.target;
                if (bus.target > r_duty) begin
                    r_state <= UP;
                    r_busy  <= 1'b1;
                end else if (bus.target < r_duty) begin
                    r_state <= DOWN;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end else if (w_tick && r_state != IDLE) begin
                if (!w_arrive) begin
                    r_duty <= w_next_duty;
                end else begin
                    r_duty <= r_goal;
                    // Breathing turns each endpoint around instead of finishing.
                    if (w_breathe && r_state == UP) begin
                        r_state <= DOWN;
                        r_goal  <= '0;
                    end else if (w_breathe && r_state == DOWN && r_target != '0) begin
                        r_state <= UP;
                        r_goal  <= r_target;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign bus.duty = r_duty;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
